// File: rtl/gprs_wb_arb.sv
// Writeback arbiter for the 2R/1W register file: two requesters share
// the write port, one registered write stage, forwarding onto read data.
module gprs_wb_arb #(
  parameter int PRIO         = 1,
  parameter int STARVE_LIMIT = 4,
  parameter int DROP_R0      = 0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        wb_hold,
  input  logic        req0_valid,
  input  logic [4:0]  req0_addr,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_addr,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic        Regwrite,
  output logic [4:0]  A3,
  output logic [31:0] Wd,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] Rd1_rf,
  input  logic [31:0] Rd2_rf,
  output logic [31:0] Rd1,
  output logic [31:0] Rd2
);

  localparam logic [2:0] Lim      = 3'(STARVE_LIMIT);
  localparam bit         StarveEn = (STARVE_LIMIT > 0);
  localparam bit         HiIsR1   = (PRIO == 1);
  localparam bit         DropZero = (DROP_R0 != 0);

  logic        wb_vld_q, wb_vld_d;
  logic [4:0]  a3_q, a3_d;
  logic [31:0] wd_q, wd_d;
  logic [2:0]  starve_cnt_q, starve_cnt_d;

  logic        hi_v, lo_v;
  logic [4:0]  hi_addr, lo_addr;
  logic [31:0] hi_data, lo_data;
  logic        arb_en, starve_hit;
  logic        grant_hi, grant_lo, gnt;
  logic [4:0]  gnt_addr;
  logic [31:0] gnt_data;

  assign hi_v    = HiIsR1 ? req1_valid : req0_valid;
  assign lo_v    = HiIsR1 ? req0_valid : req1_valid;
  assign hi_addr = HiIsR1 ? req1_addr  : req0_addr;
  assign lo_addr = HiIsR1 ? req0_addr  : req1_addr;
  assign hi_data = HiIsR1 ? req1_data  : req0_data;
  assign lo_data = HiIsR1 ? req0_data  : req1_data;

  assign arb_en     = ~Reset & ~wb_hold;
  assign starve_hit = StarveEn && (starve_cnt_q == Lim);

  // Low side wins only when alone or once it has waited out the limit
  assign grant_hi = arb_en & hi_v & ~(lo_v & starve_hit);
  assign grant_lo = arb_en & lo_v & (~hi_v | starve_hit);
  assign gnt      = grant_hi | grant_lo;

  assign req1_ready = HiIsR1 ? grant_hi : grant_lo;
  assign req0_ready = HiIsR1 ? grant_lo : grant_hi;

  always_comb begin
    gnt_addr = lo_addr;
    gnt_data = lo_data;
    unique case (1'b1)
      grant_hi: begin
        gnt_addr = hi_addr;
        gnt_data = hi_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!wb_hold) begin
      if (!lo_v || grant_lo || !StarveEn)
        starve_cnt_d = 3'd0;
      else if (starve_cnt_q != 3'd7)
        starve_cnt_d = starve_cnt_q + 3'd1;
    end
  end

  always_comb begin
    wb_vld_d = gnt;
    a3_d     = a3_q;
    wd_d     = wd_q;
    if (gnt) begin
      a3_d = gnt_addr;
      wd_d = gnt_data;
      // Handshake completes, but a dropped r0 write never reaches the file
      if (DropZero && gnt_addr == 5'd0)
        wb_vld_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wb_vld_q     <= 1'b0;
      a3_q         <= 5'd0;
      wd_q         <= 32'd0;
      starve_cnt_q <= 3'd0;
    end else begin
      wb_vld_q     <= wb_vld_d;
      a3_q         <= a3_d;
      wd_q         <= wd_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Gate with Reset so a pending write never lands while the file resets
  assign Regwrite = wb_vld_q & ~Reset;
  assign A3       = a3_q;
  assign Wd       = wd_q;

  assign Rd1 = (Regwrite && a3_q == A1) ? wd_q : Rd1_rf;
  assign Rd2 = (Regwrite && a3_q == A2) ? wd_q : Rd2_rf;

endmodule

// File: tb/tb_gprs_wb_arb.sv
// Bench for gprs_wb_arb: directed scenarios plus a randomized run
// against a queue-free behavioural model of arbitration and writeback.
module tb_gprs_wb_arb;

  localparam int P_SL = 4;

  logic        Clk, Reset, wb_hold;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr, A1, A2;
  logic [31:0] req0_data, req1_data, Rd1_rf, Rd2_rf;

  logic        r0_rdy, r1_rdy, rw;
  logic [4:0]  a3;
  logic [31:0] wd, rd1, rd2;

  logic        s_r0_rdy, s_r1_rdy, s_rw;
  logic [4:0]  s_a3;
  logic [31:0] s_wd, s_rd1, s_rd2;

  logic        d_r0_rdy, d_r1_rdy, d_rw;
  logic [4:0]  d_a3;
  logic [31:0] d_wd, d_rd1, d_rd2;

  int vectors = 0;
  int errors  = 0;

  gprs_wb_arb #(.PRIO(1), .STARVE_LIMIT(P_SL), .DROP_R0(0)) dut (
    .Clk(Clk), .Reset(Reset), .wb_hold(wb_hold),
    .req0_valid(req0_valid), .req0_addr(req0_addr),
    .req0_data(req0_data), .req0_ready(r0_rdy),
    .req1_valid(req1_valid), .req1_addr(req1_addr),
    .req1_data(req1_data), .req1_ready(r1_rdy),
    .Regwrite(rw), .A3(a3), .Wd(wd),
    .A1(A1), .A2(A2), .Rd1_rf(Rd1_rf), .Rd2_rf(Rd2_rf),
    .Rd1(rd1), .Rd2(rd2)
  );

  gprs_wb_arb #(.PRIO(1), .STARVE_LIMIT(0), .DROP_R0(0)) dut_s0 (
    .Clk(Clk), .Reset(Reset), .wb_hold(wb_hold),
    .req0_valid(req0_valid), .req0_addr(req0_addr),
    .req0_data(req0_data), .req0_ready(s_r0_rdy),
    .req1_valid(req1_valid), .req1_addr(req1_addr),
    .req1_data(req1_data), .req1_ready(s_r1_rdy),
    .Regwrite(s_rw), .A3(s_a3), .Wd(s_wd),
    .A1(A1), .A2(A2), .Rd1_rf(Rd1_rf), .Rd2_rf(Rd2_rf),
    .Rd1(s_rd1), .Rd2(s_rd2)
  );

  gprs_wb_arb #(.PRIO(0), .STARVE_LIMIT(2), .DROP_R0(1)) dut_d (
    .Clk(Clk), .Reset(Reset), .wb_hold(wb_hold),
    .req0_valid(req0_valid), .req0_addr(req0_addr),
    .req0_data(req0_data), .req0_ready(d_r0_rdy),
    .req1_valid(req1_valid), .req1_addr(req1_addr),
    .req1_data(req1_data), .req1_ready(d_r1_rdy),
    .Regwrite(d_rw), .A3(d_a3), .Wd(d_wd),
    .A1(A1), .A2(A2), .Rd1_rf(Rd1_rf), .Rd2_rf(Rd2_rf),
    .Rd1(d_rd1), .Rd2(d_rd2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wb_hold    = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    tick();
    tick();
    req0_valid = 1'b1; req0_addr = 5'd2; req0_data = 32'h1;
    req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h2;
    #1;
    vectors++;
    if ({r0_rdy, r1_rdy} !== 2'b00) begin
      errors++;
      $display("FAIL rst_ready: got %b want 00", {r0_rdy, r1_rdy});
    end
    vectors++;
    if ({rw, a3, wd} !== 38'd0) begin
      errors++;
      $display("FAIL rst_vals: got rw=%b a3=%0d wd=%h want 0", rw, a3, wd);
    end
    Reset = 1'b0;
    req1_valid = 1'b0;
    req0_addr = 5'd5; req0_data = 32'hDEAD;
    #1;
    vectors++;
    if (r0_rdy !== 1'b1) begin
      errors++;
      $display("FAIL rst_g0: got %b want 1", r0_rdy);
    end
    tick();
    req0_valid = 1'b0;
    vectors++;
    if ({rw, a3, wd} !== {1'b1, 5'd5, 32'hDEAD}) begin
      errors++;
      $display("FAIL pre_rst_wb: got %b %0d %h want 1 5 dead", rw, a3, wd);
    end
    Reset = 1'b1;
    req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h99;
    #1;
    vectors++;
    if ({rw, r1_rdy} !== 2'b00) begin
      errors++;
      $display("FAIL rst_kill: got rw=%b r1=%b want 0 0", rw, r1_rdy);
    end
    tick();
    vectors++;
    if ({rw, a3, wd} !== 38'd0) begin
      errors++;
      $display("FAIL rst_clr: got %b %0d %h want 0 0 0", rw, a3, wd);
    end
    Reset = 1'b0;
    #1;
    vectors++;
    if (r1_rdy !== 1'b1) begin
      errors++;
      $display("FAIL rst_held_req: got %b want 1", r1_rdy);
    end
    tick();
    req1_valid = 1'b0;
    vectors++;
    if ({rw, a3, wd} !== {1'b1, 5'd9, 32'h99}) begin
      errors++;
      $display("FAIL rst_after_wb: got %b %0d %h want 1 9 99", rw, a3, wd);
    end
    tick();
  endtask

  task automatic test_single;
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h11;
    #1;
    vectors++;
    if ({r0_rdy, r1_rdy} !== 2'b10) begin
      errors++;
      $display("FAIL single_rdy: got %b want 10", {r0_rdy, r1_rdy});
    end
    tick();
    req0_valid = 1'b0;
    vectors++;
    if ({rw, a3, wd} !== {1'b1, 5'd3, 32'h11}) begin
      errors++;
      $display("FAIL single_wb: got %b %0d %h want 1 3 11", rw, a3, wd);
    end
    tick();
    vectors++;
    if ({rw, a3} !== {1'b0, 5'd3}) begin
      errors++;
      $display("FAIL single_drain: got rw=%b a3=%0d want 0 3", rw, a3);
    end
  endtask

  task automatic test_starve;
    int n0, n1;
    logic want0;
    logic [4:0] exp_a;
    idle();
    n0 = 0; n1 = 0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req0_addr = 5'(10 + n0); req0_data = 32'(n0);
      req1_addr = 5'(20 + n1); req1_data = 32'(n1);
      want0 = (i % 5 == 4);
      exp_a = want0 ? req0_addr : req1_addr;
      #1;
      vectors++;
      if ({r0_rdy, r1_rdy} !== {want0, ~want0}) begin
        errors++;
        $display("FAIL starve_pat[%0d]: got %b want %b", i,
                 {r0_rdy, r1_rdy}, {want0, ~want0});
      end
      tick();
      vectors++;
      if ({rw, a3} !== {1'b1, exp_a}) begin
        errors++;
        $display("FAIL starve_a3[%0d]: got %b %0d want 1 %0d", i, rw, a3, exp_a);
      end
      if (want0) n0++;
      else n1++;
    end
    idle();
  endtask

  task automatic test_static;
    logic [4:0] exp_a;
    idle();
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h5;
    req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req1_addr = 5'(i + 12); req1_data = 32'(i);
      exp_a = req1_addr;
      #1;
      vectors++;
      if ({s_r0_rdy, s_r1_rdy} !== 2'b01) begin
        errors++;
        $display("FAIL static_pat[%0d]: got %b want 01", i, {s_r0_rdy, s_r1_rdy});
      end
      tick();
      vectors++;
      if ({s_rw, s_a3} !== {1'b1, exp_a}) begin
        errors++;
        $display("FAIL static_a3[%0d]: got %b %0d want 1 %0d", i, s_rw, s_a3, exp_a);
      end
    end
    idle();
  endtask

  task automatic test_forward;
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'hCAFE;
    A1 = 5'd7; A2 = 5'd6; Rd1_rf = 32'd1; Rd2_rf = 32'd2;
    #1;
    vectors++;
    if ({rd1, rd2} !== {32'd1, 32'd2}) begin
      errors++;
      $display("FAIL fwd_none: got %h %h want 1 2", rd1, rd2);
    end
    tick();
    req0_valid = 1'b0;
    vectors++;
    if ({rd1, rd2} !== {32'hCAFE, 32'd2}) begin
      errors++;
      $display("FAIL fwd_hit: got %h %h want cafe 2", rd1, rd2);
    end
    A1 = 5'd3; A2 = 5'd7;
    #1;
    vectors++;
    if ({rd1, rd2} !== {32'd1, 32'hCAFE}) begin
      errors++;
      $display("FAIL fwd_hit2: got %h %h want 1 cafe", rd1, rd2);
    end
    tick();
  endtask

  task automatic test_drop;
    req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'hBEEF;
    A1 = 5'd0; A2 = 5'd1; Rd1_rf = 32'h3; Rd2_rf = 32'h4;
    #1;
    vectors++;
    if ({d_r0_rdy, r0_rdy} !== 2'b11) begin
      errors++;
      $display("FAIL drop_rdy: got %b want 11", {d_r0_rdy, r0_rdy});
    end
    tick();
    req0_valid = 1'b0;
    vectors++;
    if ({d_rw, d_rd1} !== {1'b0, 32'h3}) begin
      errors++;
      $display("FAIL drop_wb: got %b %h want 0 3", d_rw, d_rd1);
    end
    vectors++;
    if ({rw, a3, rd1} !== {1'b1, 5'd0, 32'hBEEF}) begin
      errors++;
      $display("FAIL r0_legal: got %b %0d %h want 1 0 beef", rw, a3, rd1);
    end
    req0_valid = 1'b1; req0_addr = 5'd4;
    tick();
    req0_valid = 1'b0;
    vectors++;
    if ({d_rw, d_a3} !== {1'b1, 5'd4}) begin
      errors++;
      $display("FAIL drop_nz: got %b %0d want 1 4", d_rw, d_a3);
    end
    tick();
  endtask

  task automatic test_hold;
    wb_hold = 1'b1;
    req1_valid = 1'b1; req1_addr = 5'd17; req1_data = 32'h77;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if ({r0_rdy, r1_rdy} !== 2'b00) begin
        errors++;
        $display("FAIL hold_rdy[%0d]: got %b want 00", i, {r0_rdy, r1_rdy});
      end
      tick();
      vectors++;
      if (rw !== 1'b0) begin
        errors++;
        $display("FAIL hold_rw[%0d]: got %b want 0", i, rw);
      end
    end
    wb_hold = 1'b0;
    #1;
    vectors++;
    if (r1_rdy !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: got %b want 1", r1_rdy);
    end
    tick();
    req1_valid = 1'b0;
    vectors++;
    if ({rw, a3, wd} !== {1'b1, 5'd17, 32'h77}) begin
      errors++;
      $display("FAIL hold_wb: got %b %0d %h want 1 17 77", rw, a3, wd);
    end
    tick();
  endtask

  // Model: the waiting low-priority side is let through after P_SL
  // consecutive losses; writes appear one cycle after acceptance.
  task automatic test_random;
    logic m_vld;
    logic [4:0] m_a3;
    logic [31:0] m_wd, e1, e2;
    int losses;
    logic g0, g1;
    Reset = 1'b1;
    idle();
    Reset = 1'b0;
    m_vld = 1'b0; m_a3 = 5'd0; m_wd = 32'd0; losses = 0;
    for (int i = 0; i < 400; i++) begin
      if (!req0_valid && ($urandom % 3 != 0)) begin
        req0_valid = 1'b1;
        req0_addr = 5'($urandom);
        req0_data = $urandom;
      end
      if (!req1_valid && ($urandom % 3 != 0)) begin
        req1_valid = 1'b1;
        req1_addr = 5'($urandom);
        req1_data = $urandom;
      end
      wb_hold = ($urandom % 7 == 0);
      A1 = ($urandom % 2 == 0) ? m_a3 : 5'($urandom);
      A2 = ($urandom % 2 == 0) ? m_a3 : 5'($urandom);
      Rd1_rf = $urandom;
      Rd2_rf = $urandom;
      g0 = 1'b0; g1 = 1'b0;
      if (!wb_hold) begin
        if (req0_valid && req1_valid) begin
          if (losses == P_SL) g0 = 1'b1;
          else g1 = 1'b1;
        end else begin
          g0 = req0_valid;
          g1 = req1_valid;
        end
      end
      e1 = (m_vld && m_a3 == A1) ? m_wd : Rd1_rf;
      e2 = (m_vld && m_a3 == A2) ? m_wd : Rd2_rf;
      #1;
      vectors++;
      if ({r0_rdy, r1_rdy} !== {g0, g1}) begin
        errors++;
        $display("FAIL rnd_rdy[%0d]: got %b want %b", i, {r0_rdy, r1_rdy}, {g0, g1});
      end
      vectors++;
      if ({rw, a3, wd} !== {m_vld, m_a3, m_wd}) begin
        errors++;
        $display("FAIL rnd_wb[%0d]: got %b %0d %h want %b %0d %h",
                 i, rw, a3, wd, m_vld, m_a3, m_wd);
      end
      vectors++;
      if ({rd1, rd2} !== {e1, e2}) begin
        errors++;
        $display("FAIL rnd_fwd[%0d]: got %h %h want %h %h", i, rd1, rd2, e1, e2);
      end
      if (!wb_hold) begin
        if (!req0_valid || g0) losses = 0;
        else losses++;
      end
      m_vld = g0 | g1;
      if (g0) begin
        m_a3 = req0_addr;
        m_wd = req0_data;
      end else if (g1) begin
        m_a3 = req1_addr;
        m_wd = req1_data;
      end
      tick();
      if (g0) req0_valid = 1'b0;
      if (g1) req1_valid = 1'b0;
    end
    idle();
  endtask

  initial begin
    Reset = 1'b1; wb_hold = 1'b0;
    req0_valid = 1'b0; req0_addr = 5'd0; req0_data = 32'd0;
    req1_valid = 1'b0; req1_addr = 5'd0; req1_data = 32'd0;
    A1 = 5'd0; A2 = 5'd0; Rd1_rf = 32'd0; Rd2_rf = 32'd0;
    test_reset();
    test_single();
    test_starve();
    test_static();
    test_forward();
    test_drop();
    test_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
